// File: rtl/bus_fabric_pkg.sv
// Shared types and constants for the bus fabric: FSM states, bus-error data
// pattern and sizing helpers.
package bus_fabric_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        ERR
    } state_e;

    localparam int            MAX_SLAVES   = 16;
    localparam int            CNT_W        = 16;
    localparam logic [63:0]   BUS_ERR_DATA = '1;

    // Width of a slave index; never narrower than one bit.
    function automatic int sel_w_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_fabric_if.sv
// Bundle of master-side and slave-side bus signals around the fabric.
// The fabric uses the slave modport; the environment uses the master modport.
interface bus_fabric_if #(
    parameter int NUM_SLAVES   = 8,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 16,
    parameter int SLAVE_ADDR_W = 24
);
    logic [ADDR_W-1:0]            master_addr;
    logic [DATA_W-1:0]            master_write;
    logic [DATA_W-1:0]            master_read;
    logic                         master_uds;
    logic                         master_lds;
    logic                         rw;
    logic                         master_ack;
    logic                         master_err;
    logic [ADDR_W-1:0]            err_addr;
    logic [SLAVE_ADDR_W-1:0]      slave_addr;
    logic [DATA_W-1:0]            slave_write;
    logic [NUM_SLAVES*DATA_W-1:0] slave_read;
    logic [NUM_SLAVES-1:0]        slave_uds;
    logic [NUM_SLAVES-1:0]        slave_lds;
    logic [NUM_SLAVES-1:0]        slave_ack;

    modport slave (
        input  master_addr, master_write, master_uds, master_lds, rw,
               slave_read, slave_ack,
        output master_read, master_ack, master_err, err_addr,
               slave_addr, slave_write, slave_uds, slave_lds
    );

    modport master (
        output master_addr, master_write, master_uds, master_lds, rw,
               slave_read, slave_ack,
        input  master_read, master_ack, master_err, err_addr,
               slave_addr, slave_write, slave_uds, slave_lds
    );

endinterface

// File: rtl/bus_fabric_decode.sv
// Combinational address decoder: base/mask window match per slave, lowest
// matching index wins.
module bus_fabric_decode
    import bus_fabric_pkg::*;
#(
    parameter int                       NUM_SLAVES = 8,
    parameter int                       ADDR_W     = 32,
    parameter int                       SEL_W      = sel_w_f(NUM_SLAVES),
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = '0
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_any_o,
    output logic [SEL_W-1:0]  sel_o
);

    logic [NUM_SLAVES-1:0] hit;

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_hit
            assign hit[gi] = ((addr_i & ADDR_W'(SLAVE_MASK[gi*32 +: 32]))
                              == ADDR_W'(SLAVE_BASE[gi*32 +: 32]));
        end
    endgenerate

    // Scan downwards so the lowest matching index is the final assignment.
    always_comb begin
        sel_o = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_o = SEL_W'(i);
            end
        end
    end

    assign hit_any_o = |hit;

endmodule

// File: rtl/bus_fabric.sv
// 68k-style master-to-N-slave fabric: registered handshake with ack held until
// the master drops its strobes, plus unmapped-address and timeout bus errors.
module bus_fabric
    import bus_fabric_pkg::*;
#(
    parameter int                       NUM_SLAVES   = 8,
    parameter int                       ADDR_W       = 32,
    parameter int                       DATA_W       = 16,
    parameter int                       SLAVE_ADDR_W = 24,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE   = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK   = {NUM_SLAVES{32'h0}},
    parameter int                       TIMEOUT      = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    bus_fabric_if.slave  bus
);

    localparam int SEL_W = sel_w_f(NUM_SLAVES);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   read_q, read_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

    logic                req;
    logic                hit_any;
    logic [SEL_W-1:0]    hit_sel;
    logic [DATA_W-1:0]   rd_arr [NUM_SLAVES];

    bus_fabric_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .SEL_W      (SEL_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .addr_i    (bus.master_addr),
        .hit_any_o (hit_any),
        .sel_o     (hit_sel)
    );

    assign req = bus.master_uds | bus.master_lds;

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
            assign rd_arr[gi]        = bus.slave_read[gi*DATA_W +: DATA_W];
            assign bus.slave_uds[gi] = (state_q == ACCESS) && (sel_q == SEL_W'(gi)) && bus.master_uds;
            assign bus.slave_lds[gi] = (state_q == ACCESS) && (sel_q == SEL_W'(gi)) && bus.master_lds;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        read_d     = read_q;
        err_addr_d = err_addr_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit_any) begin
                        sel_d   = hit_sel;
                        cnt_d   = '0;
                        state_d = ACCESS;
                    end else begin
                        read_d     = DATA_W'(BUS_ERR_DATA);
                        err_addr_d = bus.master_addr;
                        state_d    = ERR;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A dropped request abandons the cycle before any ack or timeout.
                if (!req) begin
                    state_d = IDLE;
                end else if (bus.slave_ack[sel_q]) begin
                    if (bus.rw) begin
                        read_d = rd_arr[sel_q];
                    end
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    read_d     = DATA_W'(BUS_ERR_DATA);
                    err_addr_d = bus.master_addr;
                    state_d    = ERR;
                end
            end
            DONE, ERR: begin
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            cnt_q      <= '0;
            read_q     <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            read_q     <= read_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign bus.master_ack  = (state_q == DONE) || (state_q == ERR);
    assign bus.master_err  = (state_q == ERR);
    assign bus.master_read = read_q;
    assign bus.err_addr    = err_addr_q;
    assign bus.slave_addr  = bus.master_addr[SLAVE_ADDR_W-1:0];
    assign bus.slave_write = bus.master_write;

endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric: directed cases from the address map plus
// randomized transactions against a transaction-level reference model.
module tb_bus_fabric;

    localparam int NS  = 5;
    localparam int AW  = 32;
    localparam int DW  = 16;
    localparam int SAW = 24;
    localparam int TO  = 8;

    // boot, uart, leds, spi (overlaps leds), timer
    localparam logic [31:0] WIN_BASE [NS] = '{32'h0000_0000, 32'h0080_0000, 32'h0080_2000,
                                              32'h0080_2000, 32'h0080_4000};
    localparam logic [31:0] WIN_MASK [NS] = '{32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000,
                                              32'hFFFF_E000, 32'hFFFF_F000};
    localparam logic [NS*32-1:0] BASE = {WIN_BASE[4], WIN_BASE[3], WIN_BASE[2], WIN_BASE[1], WIN_BASE[0]};
    localparam logic [NS*32-1:0] MASK = {WIN_MASK[4], WIN_MASK[3], WIN_MASK[2], WIN_MASK[1], WIN_MASK[0]};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bus_fabric_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .SLAVE_ADDR_W(SAW)) bus ();

    bus_fabric #(
        .NUM_SLAVES   (NS),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .SLAVE_ADDR_W (SAW),
        .SLAVE_BASE   (BASE),
        .SLAVE_MASK   (MASK),
        .TIMEOUT      (TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int             n_checks = 0;
    int             n_fail   = 0;
    int             txn_no   = 0;
    int             ack_delay = 1000;
    int             hi_cnt [NS];
    logic [NS-1:0]  junk = '0;
    logic [DW-1:0]  sdata [NS];
    logic [DW-1:0]  m_read = '0;
    logic [AW-1:0]  m_err_addr = '0;

    // Slave responders: ack after ack_delay strobed cycles; unselected ports babble.
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            hi_cnt[i] <= (bus.slave_uds[i] | bus.slave_lds[i]) ? hi_cnt[i] + 1 : 0;
        end
    end

    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_slv
            assign bus.slave_ack[gi] = (bus.slave_uds[gi] | bus.slave_lds[gi])
                                       ? (hi_cnt[gi] == ack_delay) : junk[gi];
            assign bus.slave_read[gi*DW +: DW] = sdata[gi];
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int find_slave(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & WIN_MASK[i]) == WIN_BASE[i]) return i;
        end
        return -1;
    endfunction

    task automatic run_txn(input logic [31:0] addr, input logic rw_v, input logic u,
                           input logic l, input logic [15:0] wd, input int dly);
        int            tgt, exp_ack, exp_stb, ack_cyc, stb_cnt, bad_stb, bad_hold, hold;
        logic          exp_err;
        logic [NS-1:0] exp_u, exp_l;
        tgt = find_slave(addr);
        for (int i = 0; i < NS; i++) sdata[i] = DW'($urandom);
        ack_delay = dly;
        exp_u = '0;
        exp_l = '0;
        if (tgt < 0) begin
            exp_ack = 1; exp_stb = 0; exp_err = 1'b1;
        end else begin
            exp_u[tgt] = u;
            exp_l[tgt] = l;
            if (dly < TO) begin
                exp_ack = dly + 2; exp_stb = dly + 1; exp_err = 1'b0;
            end else begin
                exp_ack = TO + 1; exp_stb = TO; exp_err = 1'b1;
            end
        end
        if (exp_err) begin
            m_read = '1;
            m_err_addr = addr;
        end else if (rw_v) begin
            m_read = sdata[tgt];
        end

        @(negedge clk);
        bus.master_addr  = addr;
        bus.rw           = rw_v;
        bus.master_write = wd;
        bus.master_uds   = u;
        bus.master_lds   = l;
        ack_cyc = 0; stb_cnt = 0; bad_stb = 0;
        for (int k = 1; k <= 40 && ack_cyc == 0; k++) begin
            @(negedge clk);
            junk = NS'($urandom);
            if (k == 1) begin
                chk("slave_addr", 32'(bus.slave_addr), {8'h00, addr[23:0]});
                chk("slave_write", 32'(bus.slave_write), 32'(wd));
            end
            if (bus.master_ack) begin
                ack_cyc = k;
            end else if ((bus.slave_uds | bus.slave_lds) != '0) begin
                stb_cnt++;
                if (bus.slave_uds != exp_u || bus.slave_lds != exp_l) bad_stb++;
            end
        end
        chk("ack_cycle", ack_cyc, exp_ack);
        chk("strobe_cycles", stb_cnt, exp_stb);
        chk("strobe_lanes", bad_stb, 0);
        chk("master_err", 32'(bus.master_err), 32'(exp_err));
        chk("master_read", 32'(bus.master_read), 32'(m_read));
        chk("err_addr", bus.err_addr, m_err_addr);

        hold = $urandom_range(1, 3);
        bad_hold = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            junk = NS'($urandom);
            if (!bus.master_ack || (bus.slave_uds | bus.slave_lds) != '0) bad_hold++;
        end
        chk("ack_hold", bad_hold, 0);
        bus.master_uds = 1'b0;
        bus.master_lds = 1'b0;
        @(negedge clk);
        chk("ack_release", 32'(bus.master_ack), 0);
        txn_no++;
        $display("txn %0d addr=%h rw=%0d uds=%0d lds=%0d tgt=%0d dly=%0d ack_cyc=%0d err=%0d read=%h",
                 txn_no, addr, rw_v, u, l, tgt, dly, ack_cyc, bus.master_err, bus.master_read);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r, v, dly;
        logic [31:0] a;
        bus.master_addr  = '0;
        bus.master_write = '0;
        bus.master_uds   = 1'b0;
        bus.master_lds   = 1'b0;
        bus.rw           = 1'b1;
        for (int i = 0; i < NS; i++) sdata[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(bus.master_ack), 0);
        chk("rst_err", 32'(bus.master_err), 0);
        chk("rst_read", 32'(bus.master_read), 0);
        chk("rst_err_addr", bus.err_addr, 0);
        chk("rst_strobes", 32'(bus.slave_uds | bus.slave_lds), 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_txn(32'h0000_0100, 1'b1, 1'b1, 1'b1, 16'h0000, 3);
        chk("boot_read_data", 32'(bus.master_read), 32'h0000_0000 | 32'(m_read));
        run_txn(32'h0080_0010, 1'b0, 1'b0, 1'b1, 16'h0055, 1);
        run_txn(32'h00F0_0000, 1'b1, 1'b1, 1'b1, 16'h0000, 0);
        chk("unmapped_read", 32'(bus.master_read), 32'h0000_FFFF);
        chk("unmapped_addr", bus.err_addr, 32'h00F0_0000);
        run_txn(32'h0080_4002, 1'b1, 1'b1, 1'b1, 16'h0000, 100);
        run_txn(32'h0080_2100, 1'b1, 1'b1, 1'b0, 16'h0000, 2);

        // Reset in the middle of an access with the request still asserted.
        ack_delay = 1000;
        @(negedge clk);
        bus.master_addr = 32'h0080_0020;
        bus.rw          = 1'b1;
        bus.master_uds  = 1'b1;
        bus.master_lds  = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_strobe", 32'(bus.slave_uds[1] & bus.slave_lds[1]), 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_strobes", 32'(bus.slave_uds | bus.slave_lds), 0);
        chk("midrst_ack", 32'(bus.master_ack), 0);
        chk("midrst_err_addr", bus.err_addr, 0);
        bus.master_uds = 1'b0;
        bus.master_lds = 1'b0;
        reset_n = 1'b1;
        m_read = '0;
        m_err_addr = '0;
        @(negedge clk);
        run_txn(32'h0080_3004, 1'b1, 1'b1, 1'b1, 16'h0000, 0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 5);
            if (r < NS) a = WIN_BASE[r] | ($urandom & ~WIN_MASK[r]);
            else        a = $urandom;
            v   = $urandom_range(1, 3);
            dly = $urandom_range(0, 9);
            run_txn(a, 1'($urandom), v[1], v[0], 16'($urandom), dly);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
- Parametrised successor to the fixed five-slave device multiplexer between the TG68 master port and the peripherals (boot_device, uart, leds_dev, spi, timer).
- Generalised to NUM_SLAVES slaves, each with a parameter-defined base/mask address window.
- Registered, 68k-style handshake: ack is held until the master drops its strobes.
- Adds unmapped-address and no-ack timeout bus errors, with a captured error address.

Parameters:
NUM_SLAVES, 8, number of slave ports (1..16)
ADDR_W, 32, master address width
DATA_W, 16, data bus width
SLAVE_ADDR_W, 24, low address bits forwarded to slaves
SLAVE_BASE, {NUM_SLAVES{32'h0}}, flattened base addresses, slave i at [i*32+:32]
SLAVE_MASK, {NUM_SLAVES{32'h0}}, flattened compare masks, slave i at [i*32+:32]
TIMEOUT, 255, cycles in ACCESS without slave ack before a bus error (1..65535)

Ports:
clk  in  1  system clock; single clock domain
reset_n  in  1  synchronous, active-low reset
master_addr  in  ADDR_W  master byte address
master_write  in  DATA_W  master write data
master_read  out  DATA_W  read data returned to master
master_uds  in  1  active-high upper-byte strobe
master_lds  in  1  active-high lower-byte strobe
rw  in  1  1 = read, 0 = write
master_ack  out  1  transfer complete (drives ~dtack)
master_err  out  1  qualifies master_ack as a bus error
err_addr  out  ADDR_W  address of the most recent bus error
slave_addr  out  SLAVE_ADDR_W  master_addr[SLAVE_ADDR_W-1:0], shared by all slaves
slave_write  out  DATA_W  master_write, broadcast to all slaves
slave_read  in  NUM_SLAVES*DATA_W  slave i read data at [i*DATA_W+:DATA_W]
slave_uds  out  NUM_SLAVES  per-slave upper strobe
slave_lds  out  NUM_SLAVES  per-slave lower strobe
slave_ack  in  NUM_SLAVES  per-slave ack

Behaviour:
- Reset: state IDLE; master_ack=0; master_err=0; master_read=0; err_addr=0; slave_uds=slave_lds=0.
- Decode is combinational: hit[i] = ((master_addr & SLAVE_MASK[i]) == SLAVE_BASE[i]). The lowest hit index wins.
- A master request is master_uds|master_lds.
- IDLE:
  - On request with a hit: register sel, go to ACCESS, clear the timeout counter.
  - On request with no hit: go to ERR.
- ACCESS:
  - slave_uds[sel]=master_uds and slave_lds[sel]=master_lds; all other slave strobes are 0.
  - Slave strobes assert exactly 1 cycle after the request is first sampled.
  - Counter increments every cycle.
  - On slave_ack[sel]=1: latch slave_read[sel] into master_read if rw=1 (hold it if rw=0), go to DONE.
  - Else if counter==TIMEOUT-1: go to ERR.
  - If the master drops its strobes: abort to IDLE with no ack.
  - slave_ack on unselected ports is ignored.
- DONE: master_ack=1, master_err=0, all slave strobes 0. Stay until the master request drops, then go to IDLE.
- ERR:
  - master_ack=1, master_err=1, master_read=all ones. err_addr is loaded with master_addr on entry.
  - Stay until the request drops, then go to IDLE.
- A held request never starts a second access. IDLE re-arms only after the strobes have been low for at least 1 cycle.
- Latency with a zero-wait slave (ack in the first ACCESS cycle): request sampled at cycle 0; strobes at cycle 1; master_ack at cycle 2.
- slave_addr and slave_write are always driven combinationally from the master.
- Reset during any state: back to IDLE next edge, strobes and ack drop. err_addr clears to 0.

Decomposition:
- Package bus_fabric_pkg:
  - state encoding: IDLE, ACCESS, DONE, ERR
  - BUS_ERR_DATA constant: all ones
  - localparam width of sel: $clog2(NUM_SLAVES), minimum 1
- One sub-module, bus_fabric_decode: purely combinational priority decoder from master_addr to hit_any and sel index.

Test Plan:
- NUM_SLAVES=5 with windows matching the current map. Read of 0x000100 where slave0 acks after 3 cycles with 0xBEEF -> slave_uds[0]=slave_lds[0]=1 only; master_ack asserts 1 cycle after the ack; master_read=0xBEEF; master_err=0.
- Byte write 0x55 to the uart window, uds=0 and lds=1 -> only slave_lds[1] pulses; slave_write=0x0055; master_ack held while lds is high; no second strobe.
- Read of unmapped 0x00F00000 -> master_ack=1 and master_err=1 at cycle 1; master_read=0xFFFF; err_addr=0x00F00000; no slave strobe.
- TIMEOUT=8, slave never acks -> strobes high for 8 cycles, then master_err=1; strobes drop.
- Overlapping windows for slaves 2 and 3 -> only slave 2 is strobed.
- reset_n=0 mid-ACCESS -> next edge: all strobes 0, master_ack=0, err_addr=0; a subsequent access works normally.
